// File: rtl/display_scan_if.sv
// Display scan controller bus: capture inputs and the multiplexed digit outputs.
interface display_scan_if #(
   parameter int unsigned DIGITS = 4
);
   logic [4*DIGITS-1:0] value_in;
   logic [DIGITS-1:0]   dp_in;
   logic                load;
   logic                blank_lz;
   logic [3:0]          digit_code;
   logic                digit_dp;
   logic [DIGITS-1:0]   digit_en;
   logic                frame_done;

   // Driver side: supplies values and observes the scan
   modport master (
      output value_in, dp_in, load, blank_lz,
      input  digit_code, digit_dp, digit_en, frame_done
   );

   // Controller side
   modport slave (
      input  value_in, dp_in, load, blank_lz,
      output digit_code, digit_dp, digit_en, frame_done
   );
endinterface

// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scan controller: a guard blank precedes each digit,
// new values are double-buffered and only take effect at frame boundaries.
module display_scan_controller #(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned ON_CYCLES    = 40000,
   parameter int unsigned BLANK_CYCLES = 2000
) (
   input logic          clk,
   input logic          rst,
   display_scan_if.slave bus
);
   localparam int unsigned MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
   localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam int unsigned IW         = $clog2(DIGITS);
   localparam int unsigned VW         = 4 * DIGITS;

   localparam logic [CW-1:0]     ON_LAST    = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] ONE_HOT0   = DIGITS'(1);

   typedef enum logic {BLANK, ON} state_t;

   state_t            state;
   logic [IW-1:0]     idx;
   logic [CW-1:0]     cnt;
   logic [VW-1:0]     pend_val;
   logic [DIGITS-1:0] pend_dp;
   logic [VW-1:0]     disp_val;
   logic [DIGITS-1:0] disp_dp;
   logic              frame_pulse;
   logic [DIGITS-1:0] blank_mask;
   logic              upper_nz;

   // Scan sequencer plus pending/display double buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= BLANK;
         idx         <= '0;
         cnt         <= '0;
         pend_val    <= '0;
         pend_dp     <= '0;
         disp_val    <= '0;
         disp_dp     <= '0;
         frame_pulse <= 1'b0;
      end else begin
         frame_pulse <= 1'b0;
         if (bus.load) begin
            pend_val <= bus.value_in;
            pend_dp  <= bus.dp_in;
         end
         if (state == BLANK) begin
            if (cnt == BLANK_LAST) begin
               state <= ON;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            if (cnt == ON_LAST) begin
               state <= BLANK;
               cnt   <= '0;
               if (idx == IDX_LAST) begin
                  idx         <= '0;
                  frame_pulse <= 1'b1;
                  // A load coinciding with the frame edge goes straight to the display
                  if (bus.load) begin
                     disp_val <= bus.value_in;
                     disp_dp  <= bus.dp_in;
                  end else begin
                     disp_val <= pend_val;
                     disp_dp  <= pend_dp;
                  end
               end else begin
                  idx <= idx + IW'(1);
               end
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

   // Leading-zero mask: digit k blanks when it and all higher nibbles are zero and its dp is clear
   always_comb begin
      blank_mask = '0;
      upper_nz   = 1'b0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         upper_nz      = upper_nz | (disp_val[4*k +: 4] != 4'h0);
         blank_mask[k] = bus.blank_lz & ~upper_nz & ~disp_dp[k];
      end
   end

   // Outputs decode from registered state; the code is valid during BLANK so it settles early
   assign bus.digit_code = disp_val[{idx, 2'b00} +: 4];
   assign bus.digit_dp   = disp_dp[idx];
   assign bus.digit_en   = ((state == ON) && !blank_mask[idx]) ? (ONE_HOT0 << idx) : '0;
   assign bus.frame_done = frame_pulse;
endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller (DIGITS=4, ON=4, BLANK=2).
module tb_display_scan_controller;
   localparam int unsigned DIGITS       = 4;
   localparam int unsigned ON_CYCLES    = 4;
   localparam int unsigned BLANK_CYCLES = 2;
   localparam int unsigned VISIT        = ON_CYCLES + BLANK_CYCLES;
   localparam int unsigned FRAME        = DIGITS * VISIT;

   logic clk = 1'b0;
   logic rst = 1'b1;

   display_scan_if #(.DIGITS(DIGITS)) bus ();

   display_scan_controller #(
      .DIGITS(DIGITS), .ON_CYCLES(ON_CYCLES), .BLANK_CYCLES(BLANK_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Expected content of one complete frame; per-digit fields packed digit 0 lowest
   typedef struct packed {
      logic [15:0] codes;
      logic [3:0]  dps;
      logic [15:0] ens;
   } frame_t;

   frame_t exp_q[$];
   int vectors     = 0;
   int miscompares = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endfunction

   function automatic void push(logic [15:0] codes, logic [3:0] dps, logic [15:0] ens);
      frame_t e;
      e.codes = codes;
      e.dps   = dps;
      e.ens   = ens;
      exp_q.push_back(e);
   endfunction

   // Monitor: rebuild each frame from the outputs, compare at the next frame_done
   frame_t   obs;
   logic [3:0] blank_code [DIGITS];
   bit       consistent;
   bit       in_frame = 1'b0;
   bit       restart  = 1'b0;
   int       j        = 0;
   int       frame_no = 0;
   int       mk, mp;
   frame_t   e_pop;

   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
         restart  = 1'b1;
      end else begin
         if (bus.frame_done || restart) begin
            if (bus.frame_done && in_frame) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected frame %0d: no expectation queued", frame_no);
               end else begin
                  e_pop = exp_q.pop_front();
                  check($sformatf("frame%0d codes", frame_no), 32'(obs.codes), 32'(e_pop.codes));
                  check($sformatf("frame%0d dps", frame_no), 32'(obs.dps), 32'(e_pop.dps));
                  check($sformatf("frame%0d enables", frame_no), 32'(obs.ens), 32'(e_pop.ens));
                  check($sformatf("frame%0d period", frame_no), 32'(j), 32'(FRAME));
                  check($sformatf("frame%0d stable", frame_no), 32'(consistent), 32'd1);
               end
               frame_no++;
            end
            j          = 0;
            in_frame   = 1'b1;
            restart    = 1'b0;
            obs        = '0;
            consistent = 1'b1;
         end
         if (in_frame) begin
            mk = j / VISIT;
            mp = j % VISIT;
            if (mk < DIGITS) begin
               if (mp < BLANK_CYCLES) begin
                  if (bus.digit_en != 4'b0000) consistent = 1'b0;
                  if (mp == BLANK_CYCLES - 1) blank_code[mk] = bus.digit_code;
               end else if (mp == BLANK_CYCLES) begin
                  obs.codes[4*mk +: 4] = bus.digit_code;
                  obs.dps[mk]          = bus.digit_dp;
                  obs.ens[4*mk +: 4]   = bus.digit_en;
                  if (bus.digit_code != blank_code[mk]) consistent = 1'b0;
               end else begin
                  if (bus.digit_en != obs.ens[4*mk +: 4]) consistent = 1'b0;
                  if (bus.digit_code != obs.codes[4*mk +: 4]) consistent = 1'b0;
               end
            end
            j++;
         end
      end
   end

   task automatic wait_frame();
      bit seen = 1'b0;
      for (int i = 0; i < 3 * FRAME && !seen; i++) begin
         @(negedge clk);
         if (bus.frame_done) seen = 1'b1;
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL frame_done timeout: got none, expected pulse within %0d cycles", 3 * FRAME);
      end
   endtask

   task automatic skip(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(logic [15:0] v, logic [3:0] dp);
      bus.value_in = v;
      bus.dp_in    = dp;
      bus.load     = 1'b1;
      @(negedge clk);
      bus.load     = 1'b0;
   endtask

   // Stimulus: each frame's expectation is queued as the frame begins
   initial begin
      bus.value_in = 16'h9999;
      bus.dp_in    = 4'hF;
      bus.load     = 1'b1;
      bus.blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      check("reset digit_en", 32'(bus.digit_en), 32'h0);
      check("reset digit_code", 32'(bus.digit_code), 32'h0);
      check("reset digit_dp", 32'(bus.digit_dp), 32'h0);
      check("reset frame_done", 32'(bus.frame_done), 32'h0);
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.load     = 1'b0;
      bus.dp_in    = 4'h0;
      bus.value_in = 16'h0000;

      push(16'h0000, 4'b0000, 16'h8421);      // frame 0: zeros, load in reset ignored
      wait_frame();
      push(16'h0000, 4'b0000, 16'h8421);      // frame 1: mid-frame load not shown yet
      skip(5);
      do_load(16'h1234, 4'b0100);
      wait_frame();
      push(16'h1234, 4'b0100, 16'h8421);      // frame 2: 4,3,2,1 with dp on digit 2
      skip(3);
      bus.blank_lz = 1'b1;
      do_load(16'h00A5, 4'b0000);
      wait_frame();
      push(16'h00A5, 4'b0000, 16'h0021);      // frame 3: digits 2-3 blanked
      skip(7);
      do_load(16'h0000, 4'b0010);
      wait_frame();
      push(16'h0000, 4'b0010, 16'h0021);      // frame 4: dp keeps digit 1 lit
      skip(FRAME - 1);
      bus.value_in = 16'hBEEF;
      bus.dp_in    = 4'b0000;
      bus.load     = 1'b1;                     // high across the transfer edge
      wait_frame();
      bus.load     = 1'b0;
      push(16'hBEEF, 4'b0000, 16'h8421);      // frame 5: bypass, no frame of delay
      wait_frame();
      push(16'hBEEF, 4'b0000, 16'h8421);      // frame 6: pending also got BEEF
      wait_frame();

      // Frame 7 is cut short by reset during digit 2's ON phase
      skip(2 * VISIT + BLANK_CYCLES + 1);
      check("pre-reset digit_en", 32'(bus.digit_en), 32'h4);
      check("pre-reset digit_code", 32'(bus.digit_code), 32'hE);
      bus.value_in = 16'h9999;
      bus.dp_in    = 4'hF;
      bus.load     = 1'b1;
      rst          = 1'b1;
      #1;
      check("async reset digit_en", 32'(bus.digit_en), 32'h0);
      check("async reset digit_code", 32'(bus.digit_code), 32'h0);
      check("async reset digit_dp", 32'(bus.digit_dp), 32'h0);
      check("async reset frame_done", 32'(bus.frame_done), 32'h0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.load     = 1'b0;
      bus.dp_in    = 4'h0;
      bus.value_in = 16'h0000;

      push(16'h0000, 4'b0000, 16'h0001);      // frame 8: all zero, only digit 0 lit
      wait_frame();
      bus.blank_lz = 1'b0;
      push(16'h0000, 4'b0000, 16'h8421);      // frame 9: pending still zero
      wait_frame();
      skip(2);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at 100000 time units");
      $fatal(1, "watchdog expired");
   end
endmodule
